// File: rtl/mem_access_unit_if.sv
// Bundle between EX, the memory-access stage, the data bus and WB.
// The master side is the memory-access stage; the slave side is its environment.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned REG_AW = 5
);
  logic              valid_i;
  logic              memRr_i;
  logic              memWr_i;
  logic [1:0]        size_i;
  logic              unsigned_i;
  logic [ADDR_W-1:0] memAddr_i;
  logic [31:0]       memData_i;
  logic [31:0]       regcData_i;
  logic [REG_AW-1:0] regcAddr_i;
  logic              regcWr_i;
  logic              stall_o;
  logic              memCe;
  logic              memWr;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       wtData;
  logic [3:0]        w_mask;
  logic [3:0]        r_mask;
  logic              memRdy_i;
  logic [31:0]       rdData_i;
  logic [31:0]       regData;
  logic [REG_AW-1:0] regAddr;
  logic              regWr;
  logic              wb_valid;
  logic              misalign_o;
  logic              bus_err_o;

  modport master (
    input  valid_i, memRr_i, memWr_i, size_i, unsigned_i, memAddr_i, memData_i,
           regcData_i, regcAddr_i, regcWr_i, memRdy_i, rdData_i,
    output stall_o, memCe, memWr, memAddr, wtData, w_mask, r_mask,
           regData, regAddr, regWr, wb_valid, misalign_o, bus_err_o
  );

  modport slave (
    output valid_i, memRr_i, memWr_i, size_i, unsigned_i, memAddr_i, memData_i,
           regcData_i, regcAddr_i, regcWr_i, memRdy_i, rdData_i,
    input  stall_o, memCe, memWr, memAddr, wtData, w_mask, r_mask,
           regData, regAddr, regWr, wb_valid, misalign_o, bus_err_o
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access stage: sized, lane-steered bus access with stall, misalignment
// detection and bus timeout; emits one registered writeback bundle per instruction.
module mem_access_unit #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 5
) (
  input logic            clk,
  input logic            rst,
  mem_access_unit_if.master bus
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        lo_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              load_q;
  logic              cwr_q;
  logic [REG_AW-1:0] raddr_q;

  logic              mem_ce_q, mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       wt_data_q;
  logic [3:0]        w_mask_q, r_mask_q;
  logic [31:0]       reg_data_q;
  logic [REG_AW-1:0] reg_addr_q;
  logic              reg_wr_q, wb_valid_q, misalign_q, bus_err_q;

  logic        busy, access, misal, start, timeout;
  logic [3:0]  mask_d;
  logic [31:0] wt_data_d, reg_data_d;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign busy    = (state_q == BUSY);
  assign access  = bus.memRr_i | bus.memWr_i;
  assign misal   = ((bus.size_i == 2'b01) & bus.memAddr_i[0]) |
                   (bus.size_i[1] & (|bus.memAddr_i[1:0]));
  assign start   = ~busy & bus.valid_i & access & ~misal;
  assign timeout = (MAX_WAIT != 0) && (cnt_q == TO_LAST);

  // Reset forces stall low at once, independent of the clock.
  assign bus.stall_o = ~rst & (start | (busy & ~bus.memRdy_i & ~timeout));

  // Byte-lane mask and replicated store data for the incoming request.
  always_comb begin
    mask_d    = 4'b1111;
    wt_data_d = bus.memData_i;
    case (bus.size_i)
      2'b00: begin
        mask_d    = 4'b0001 << bus.memAddr_i[1:0];
        wt_data_d = {4{bus.memData_i[7:0]}};
      end
      2'b01: begin
        mask_d    = bus.memAddr_i[1] ? 4'b1100 : 4'b0011;
        wt_data_d = {2{bus.memData_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select and extension of the returned word using the latched request.
  always_comb begin
    ld_b       = bus.rdData_i[{lo_q, 3'b000} +: 8];
    ld_h       = lo_q[1] ? bus.rdData_i[31:16] : bus.rdData_i[15:0];
    reg_data_d = bus.rdData_i;
    case (size_q)
      2'b00:   reg_data_d = {{24{~uns_q & ld_b[7]}}, ld_b};
      2'b01:   reg_data_d = {{16{~uns_q & ld_h[15]}}, ld_h};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lo_q       <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      load_q     <= 1'b0;
      cwr_q      <= 1'b0;
      raddr_q    <= '0;
      mem_ce_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      wt_data_q  <= '0;
      w_mask_q   <= '0;
      r_mask_q   <= '0;
      reg_data_q <= '0;
      reg_addr_q <= '0;
      reg_wr_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.valid_i) begin
          if (!access) begin
            reg_data_q <= bus.regcData_i;
            reg_addr_q <= bus.regcAddr_i;
            reg_wr_q   <= bus.regcWr_i;
            wb_valid_q <= 1'b1;
          end else if (misal) begin
            reg_addr_q <= bus.regcAddr_i;
            reg_wr_q   <= 1'b0;
            misalign_q <= 1'b1;
            wb_valid_q <= 1'b1;
          end else begin
            state_q    <= BUSY;
            cnt_q      <= '0;
            lo_q       <= bus.memAddr_i[1:0];
            size_q     <= bus.size_i;
            uns_q      <= bus.unsigned_i;
            load_q     <= ~bus.memWr_i;
            cwr_q      <= bus.regcWr_i;
            raddr_q    <= bus.regcAddr_i;
            mem_ce_q   <= 1'b1;
            mem_wr_q   <= bus.memWr_i;
            mem_addr_q <= {bus.memAddr_i[ADDR_W-1:2], 2'b00};
            wt_data_q  <= wt_data_d;
            w_mask_q   <= bus.memWr_i ? mask_d : 4'b0000;
            r_mask_q   <= bus.memWr_i ? 4'b0000 : mask_d;
          end
        end
      end else begin
        // A ready in the timeout cycle still completes normally.
        if (bus.memRdy_i || timeout) begin
          state_q    <= IDLE;
          mem_ce_q   <= 1'b0;
          mem_wr_q   <= 1'b0;
          w_mask_q   <= '0;
          r_mask_q   <= '0;
          reg_addr_q <= raddr_q;
          wb_valid_q <= 1'b1;
          if (bus.memRdy_i) begin
            reg_wr_q <= load_q & cwr_q;
            if (load_q) reg_data_q <= reg_data_d;
          end else begin
            reg_wr_q  <= 1'b0;
            bus_err_q <= 1'b1;
          end
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.memCe      = mem_ce_q;
  assign bus.memWr      = mem_wr_q;
  assign bus.memAddr    = mem_addr_q;
  assign bus.wtData     = wt_data_q;
  assign bus.w_mask     = w_mask_q;
  assign bus.r_mask     = r_mask_q;
  assign bus.regData    = reg_data_q;
  assign bus.regAddr    = reg_addr_q;
  assign bus.regWr      = reg_wr_q;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.misalign_o = misalign_q;
  assign bus.bus_err_o  = bus_err_q;

endmodule
